// File: rtl/midi_tx.sv
// midi_tx: serial MIDI OUT transmitter.
// Accepts one 24-bit message (status, data1, data2) on a one-cycle strobe while idle,
// derives the byte count from the status byte and sends the bytes back-to-back as
// 8N1 UART frames, each bit lasting CLK_HZ/BAUD cycles. Unsupported status bytes are
// ignored without leaving idle.
module midi_tx #(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 31250
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [23:0] MIDI_MSG,
    input  logic        MIDI_MSG_RDY,
    output logic        MIDI_TX,
    output logic        BUSY,
    output logic        DONE
);

    localparam int unsigned Div  = CLK_HZ / BAUD;
    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // Message length in bytes from the status byte; 0 marks a status we do not send.
    function automatic logic [2:0] msg_len(input logic [7:0] s);
        logic [2:0] len;
        case (s[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 3'd3;
            4'hC, 4'hD:                   len = 3'd2;
            4'hF:                         len = s[3] ? 3'd1 : 3'd0;
            default:                      len = 3'd0;
        endcase
        return len;
    endfunction

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic [1:0]      last_q, last_d;
    logic [23:0]     msg_q, msg_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [2:0]      in_len;
    logic            bit_end;
    logic [7:0]      cur_byte;

    assign in_len  = msg_len(MIDI_MSG[23:16]);
    assign bit_end = (cnt_q == CntMax);

    // Next-state logic: baud counter, bit/byte sequencing and message capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        last_d  = last_q;
        msg_d   = msg_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (MIDI_MSG_RDY && (in_len != 3'd0)) begin
                    state_d = StStart;
                    msg_d   = MIDI_MSG;
                    last_d  = 2'(in_len - 3'd1);
                    byte_d  = 2'd0;
                    bit_d   = 3'd0;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (byte_q < last_q) begin
                        byte_d  = byte_q + 2'd1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs are derived from the next state so the line changes on the
    // same edge the state does.
    always_comb begin
        case (byte_d)
            2'd0:    cur_byte = msg_d[23:16];
            2'd1:    cur_byte = msg_d[15:8];
            default: cur_byte = msg_d[7:0];
        endcase
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset drives the line high at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            last_q  <= 2'd0;
            msg_q   <= 24'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            msg_q   <= msg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign MIDI_TX = tx_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx at DIV=16: table of messages with hand-derived byte counts, plus
// hand-written sequences for strobe-while-busy, strobe-in-DONE-cycle and mid-frame reset.
module tb_midi_tx;

    localparam int Div = 16;

    logic        CLK;
    logic        nRST;
    logic [23:0] MIDI_MSG;
    logic        MIDI_MSG_RDY;
    logic        MIDI_TX;
    logic        BUSY;
    logic        DONE;

    int total;
    int bad;

    midi_tx #(
        .CLK_HZ(16),
        .BAUD  (1)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .MIDI_MSG    (MIDI_MSG),
        .MIDI_MSG_RDY(MIDI_MSG_RDY),
        .MIDI_TX     (MIDI_TX),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [23:0] msg;
        int          n;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Line level of frame bit b: start 0, data LSB first, stop 1, bytes in order.
    function automatic logic frame_bit(input logic [23:0] m, input int b);
        int         j;
        int         p;
        logic [7:0] by;
        j  = b / 10;
        p  = b % 10;
        by = (j == 0) ? m[23:16] : ((j == 1) ? m[15:8] : m[7:0]);
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return by[p-1];
    endfunction

    // Sends msg (optionally already strobed by the caller) and follows it cycle by cycle.
    // c counts cycles after the accept edge, sampled on falling edges. inj_c injects a
    // one-cycle strobe of inj_msg at that cycle. With chain set the task strobes next_msg
    // in the DONE cycle and returns on that same falling edge.
    task automatic run_msg(input string tag, input logic [23:0] msg, input int n,
                           input bit strobe, input int inj_c, input logic [23:0] inj_msg,
                           input bit chain, input logic [23:0] next_msg);
        int lastc;
        int busy_cnt;
        int done_cnt;
        int done_at;
        int low_cnt;
        if (strobe) begin
            MIDI_MSG     = msg;
            MIDI_MSG_RDY = 1'b1;
        end
        @(negedge CLK);
        MIDI_MSG_RDY = 1'b0;
        lastc    = (n == 0) ? 40 : (chain ? 10 * n * Div : 10 * n * Div + 1);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        low_cnt  = 0;
        for (int c = 0; c <= lastc; c++) begin
            if (BUSY) busy_cnt++;
            if (DONE) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (!MIDI_TX) low_cnt++;
            if (n > 0) begin
                if (c == 0) begin
                    chk({tag, " busy after accept"}, int'(BUSY), 1);
                    chk({tag, " start bit after accept"}, int'(MIDI_TX), 0);
                end
                if ((c % Div == Div / 2) && (c < 10 * n * Div)) begin
                    chk($sformatf("%s bit %0d", tag, c / Div), int'(MIDI_TX),
                        int'(frame_bit(msg, c / Div)));
                end
                if (c == 10 * n * Div) begin
                    chk({tag, " line high at end"}, int'(MIDI_TX), 1);
                end
            end
            if (c == inj_c) begin
                MIDI_MSG     = inj_msg;
                MIDI_MSG_RDY = 1'b1;
            end else begin
                MIDI_MSG_RDY = 1'b0;
            end
            if (chain && c == lastc) begin
                MIDI_MSG     = next_msg;
                MIDI_MSG_RDY = 1'b1;
            end
            if (c != lastc) @(negedge CLK);
        end
        if (n > 0) begin
            chk({tag, " busy cycles"}, busy_cnt, 10 * n * Div);
            chk({tag, " done count"}, done_cnt, 1);
            chk({tag, " done cycle"}, done_at, 10 * n * Div);
        end else begin
            chk({tag, " rejected busy cycles"}, busy_cnt, 0);
            chk({tag, " rejected done count"}, done_cnt, 0);
            chk({tag, " rejected line low cycles"}, low_cnt, 0);
        end
    endtask

    vec_t vecs[10];

    initial begin
        total        = 0;
        bad          = 0;
        nRST         = 1'b0;
        MIDI_MSG     = 24'd0;
        MIDI_MSG_RDY = 1'b0;

        vecs[0] = '{msg: 24'h903C64, n: 3};
        vecs[1] = '{msg: 24'hC00511, n: 2};
        vecs[2] = '{msg: 24'hF8AABB, n: 1};
        vecs[3] = '{msg: 24'h7F1234, n: 0};
        vecs[4] = '{msg: 24'hF01234, n: 0};
        vecs[5] = '{msg: 24'hB07F01, n: 3};
        vecs[6] = '{msg: 24'h90FF80, n: 3};
        vecs[7] = '{msg: 24'hD0A5C3, n: 2};
        vecs[8] = '{msg: 24'hF71234, n: 0};
        vecs[9] = '{msg: 24'hFF0000, n: 1};

        // Reset values while held in reset.
        repeat (3) @(negedge CLK);
        chk("reset tx", int'(MIDI_TX), 1);
        chk("reset busy", int'(BUSY), 0);
        chk("reset done", int'(DONE), 0);
        nRST = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 10; i++) begin
            run_msg($sformatf("vec%0d", i), vecs[i].msg, vecs[i].n, 1'b1, -1, 24'd0,
                    1'b0, 24'd0);
        end

        // Strobe while busy must be dropped: one message, one DONE.
        run_msg("drop", 24'h903C64, 3, 1'b1, 50, 24'h803C00, 1'b0, 24'd0);

        // Strobe in the DONE cycle starts the next message one cycle later.
        run_msg("chainA", 24'h903C64, 3, 1'b1, -1, 24'd0, 1'b1, 24'h803C00);
        run_msg("chainB", 24'h803C00, 3, 1'b0, -1, 24'd0, 1'b0, 24'd0);

        // Reset during the first data bit of byte 1 (bit 0 of 3C is 0).
        MIDI_MSG     = 24'h903C64;
        MIDI_MSG_RDY = 1'b1;
        @(negedge CLK);
        MIDI_MSG_RDY = 1'b0;
        repeat (11 * Div + Div / 2) @(negedge CLK);
        chk("pre-reset line low", int'(MIDI_TX), 0);
        #2;
        nRST = 1'b0;
        #1;
        chk("async reset tx", int'(MIDI_TX), 1);
        chk("async reset busy", int'(BUSY), 0);
        chk("async reset done", int'(DONE), 0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        run_msg("post-reset", 24'h903C64, 3, 1'b1, -1, 24'd0, 1'b0, 24'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
